// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter that shares one memory/L2 port among NUM_CORES L1 caches,
// with a per-transaction watchdog that aborts requests the memory never accepts.
module l1_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        req_we,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        done,
    output logic                        err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_valid,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state, state_d;
    logic [IDX_W-1:0]     last, last_d, win, win_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [NUM_CORES-1:0] gnt_d, done_d;
    logic                 err_d, mem_valid_d, mem_we_d;
    logic [DATA_W-1:0]    rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0]    mem_addr_d;

    logic                 found;
    logic [IDX_W-1:0]     cand, pick;
    logic [NUM_CORES-1:0] pick_onehot;
    logic                 pick_we;
    logic [ADDR_W-1:0]    pick_addr;
    logic [DATA_W-1:0]    pick_wdata;

    // Search starts one past the last winner and wraps, so every requester is
    // reached within NUM_CORES transactions.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        pick  = last;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_CORES);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        pick_we     = 1'b0;
        pick_addr   = '0;
        pick_wdata  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (IDX_W'(i) == pick) begin
                pick_onehot[i] = 1'b1;
                pick_we        = req_we[i];
                pick_addr      = req_addr[i*ADDR_W +: ADDR_W];
                pick_wdata     = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        state_d     = state;
        last_d      = last;
        win_d       = win;
        cnt_d       = cnt;
        gnt_d       = gnt;
        done_d      = done;
        err_d       = err;
        rdata_d     = rdata;
        mem_valid_d = mem_valid;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d     = BUSY;
                    win_d       = pick;
                    gnt_d       = pick_onehot;
                    mem_valid_d = 1'b1;
                    mem_we_d    = pick_we;
                    mem_addr_d  = pick_addr;
                    mem_wdata_d = pick_wdata;
                    cnt_d       = '0;
                end
            end
            BUSY: begin
                if (mem_ready || cnt == CNT_LAST) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    done_d      = gnt;
                    err_d       = !mem_ready;
                    rdata_d     = (mem_ready && !mem_we) ? mem_rdata : '0;
                    last_d      = win;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                done_d  = '0;
                err_d   = 1'b0;
                gnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Asynchronous reset cancels any transaction in flight: mem_valid drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= LAST_RST;
            win       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state     <= state_d;
            last      <= last_d;
            win       <= win_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            done      <= done_d;
            err       <= err_d;
            rdata     <= rdata_d;
            mem_valid <= mem_valid_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed scenarios plus randomized
// traffic against a rotating-priority-queue reference model.
module tb_l1_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            mem_valid, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;

    logic [AW-1:0]   c_addr  [N];
    logic [DW-1:0]   c_wdata [N];

    int total = 0;
    int bad   = 0;

    // Cyclic service order: front is next in line, back is the last winner.
    logic [1:0] prio_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_addr[g*AW +: AW]  = c_addr[g];
        assign req_wdata[g*DW +: DW] = c_wdata[g];
    end

    l1_mem_arbiter #(
        .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        prio_q.delete();
        for (int i = 0; i < N; i++) prio_q.push_back(2'(i));
    endtask

    function automatic logic [1:0] model_pick(input logic [N-1:0] m);
        foreach (prio_q[j]) if (m[prio_q[j]]) return prio_q[j];
        return 2'd0;
    endfunction

    task automatic model_commit(input logic [1:0] w);
        while (prio_q[$] != w) prio_q.push_back(prio_q.pop_front());
    endtask

    task automatic clear_inputs;
        req = '0; req_we = '0; mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < N; i++) begin c_addr[i] = '0; c_wdata[i] = '0; end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs;
        tick; tick;
        rst = 1'b0;
        model_reset;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs;
        tick; tick;
        total++; if (gnt !== 4'b0 || done !== 4'b0 || err !== 1'b0 || mem_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl got gnt=%b done=%b err=%b valid=%b want all zero", gnt, done, err, mem_valid);
        end
        total++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
            bad++; $display("FAIL reset_data got we=%b addr=%h wdata=%h rdata=%h want all zero", mem_we, mem_addr, mem_wdata, rdata);
        end
        rst = 1'b0;
        model_reset;
        tick;
        total++; if (gnt !== 4'b0 || mem_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle got gnt=%b valid=%b want 0000/0", gnt, mem_valid);
        end
    endtask

    task automatic test_single_read;
        req = 4'b0100; c_addr[2] = 32'h100; req_we = '0;
        tick;
        total++; if (gnt !== 4'b0100 || mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            bad++; $display("FAIL read_grant got gnt=%b valid=%b addr=%h we=%b want 0100/1/100/0", gnt, mem_valid, mem_addr, mem_we);
        end
        for (int c = 1; c <= 2; c++) begin
            tick;
            total++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || done !== 4'b0) begin
                bad++; $display("FAIL read_busy%0d got valid=%b addr=%h done=%b want 1/100/0000", c, mem_valid, mem_addr, done);
            end
        end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick;
        total++; if (done !== 4'b0100 || rdata !== 32'hDEADBEEF || err !== 1'b0 || mem_valid !== 1'b0) begin
            bad++; $display("FAIL read_done got done=%b rdata=%h err=%b valid=%b want 0100/deadbeef/0/0", done, rdata, err, mem_valid);
        end
        mem_ready = 1'b0; mem_rdata = '0;
        tick;
        total++; if (done !== 4'b0 || gnt !== 4'b0 || rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL read_resp got done=%b gnt=%b rdata=%h want 0000/0000/deadbeef", done, gnt, rdata);
        end
        req = '0;
        tick; tick;
        total++; if (gnt !== 4'b0 || mem_valid !== 1'b0) begin
            bad++; $display("FAIL read_no_regrant got gnt=%b valid=%b want 0000/0", gnt, mem_valid);
        end
    endtask

    task automatic test_write;
        req = 4'b0010; req_we = 4'b0010; c_wdata[1] = 32'h55AA; c_addr[1] = 32'h2468;
        tick;
        total++; if (gnt !== 4'b0010 || mem_we !== 1'b1 || mem_wdata !== 32'h55AA || mem_valid !== 1'b1) begin
            bad++; $display("FAIL write_grant got gnt=%b we=%b wdata=%h valid=%b want 0010/1/55aa/1", gnt, mem_we, mem_wdata, mem_valid);
        end
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick;
        total++; if (done !== 4'b0010 || rdata !== 32'h0 || err !== 1'b0 || mem_valid !== 1'b0) begin
            bad++; $display("FAIL write_done got done=%b rdata=%h err=%b valid=%b want 0010/0/0/0", done, rdata, err, mem_valid);
        end
        mem_ready = 1'b0;
        tick;
        req = '0; req_we = '0;
        tick;
        total++; if (done !== 4'b0 || gnt !== 4'b0) begin
            bad++; $display("FAIL write_after got done=%b gnt=%b want 0000/0000", done, gnt);
        end
    endtask

    task automatic test_reset_mid_busy;
        req = 4'b0001; c_addr[0] = 32'h200;
        tick;
        total++; if (gnt !== 4'b0001) begin
            bad++; $display("FAIL rstbusy_grant got gnt=%b want 0001", gnt);
        end
        tick;
        #2 rst = 1'b1;
        #1;
        total++; if (mem_valid !== 1'b0 || gnt !== 4'b0 || done !== 4'b0) begin
            bad++; $display("FAIL rstbusy_async got valid=%b gnt=%b done=%b want 0/0000/0000", mem_valid, gnt, done);
        end
        tick; tick;
        rst = 1'b0;
        req = 4'b1111; c_addr[0] = 32'h300;
        total++; if (done !== 4'b0) begin
            bad++; $display("FAIL rstbusy_nodone got done=%b want 0000", done);
        end
        tick;
        total++; if (gnt !== 4'b0001 || mem_addr !== 32'h300) begin
            bad++; $display("FAIL rstbusy_first got gnt=%b addr=%h want 0001/300", gnt, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick;
        total++; if (done !== 4'b0001 || rdata !== 32'h0BAD_F00D) begin
            bad++; $display("FAIL rstbusy_done got done=%b rdata=%h want 0001/0badf00d", done, rdata);
        end
        mem_ready = 1'b0;
        tick;
        req = '0;
        tick;
    endtask

    task automatic test_withdrawal;
        req = 4'b0010; c_addr[1] = 32'h440; req_we = '0;
        tick;
        total++; if (gnt !== 4'b0010) begin
            bad++; $display("FAIL wd_grant got gnt=%b want 0010", gnt);
        end
        req = '0; c_addr[1] = 32'h999;
        tick;
        total++; if (mem_valid !== 1'b1 || gnt !== 4'b0010 || mem_addr !== 32'h440) begin
            bad++; $display("FAIL wd_busy got valid=%b gnt=%b addr=%h want 1/0010/440", mem_valid, gnt, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        tick;
        total++; if (done !== 4'b0010 || err !== 1'b0 || rdata !== 32'hA5A5_0001) begin
            bad++; $display("FAIL wd_done got done=%b err=%b rdata=%h want 0010/0/a5a50001", done, err, rdata);
        end
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            total++; if (gnt !== 4'b0 || mem_valid !== 1'b0) begin
                bad++; $display("FAIL wd_idle%0d got gnt=%b valid=%b want 0000/0", c, gnt, mem_valid);
            end
        end
    endtask

    task automatic test_timeout;
        int vcyc;
        int guard;
        req = 4'b1000; c_addr[3] = 32'h880; mem_ready = 1'b0;
        tick;
        total++; if (gnt !== 4'b1000) begin
            bad++; $display("FAIL to_grant got gnt=%b want 1000", gnt);
        end
        vcyc  = (mem_valid === 1'b1) ? 1 : 0;
        guard = 0;
        while (mem_valid === 1'b1 && guard < TO + 10) begin
            tick;
            guard++;
            if (mem_valid === 1'b1) vcyc++;
        end
        total++; if (vcyc != TO) begin
            bad++; $display("FAIL to_valid_len got %0d cycles want %0d", vcyc, TO);
        end
        total++; if (done !== 4'b1000 || err !== 1'b1 || rdata !== 32'h0) begin
            bad++; $display("FAIL to_done got done=%b err=%b rdata=%h want 1000/1/0", done, err, rdata);
        end
        tick;
        req = '0;
        total++; if (done !== 4'b0 || err !== 1'b0 || gnt !== 4'b0) begin
            bad++; $display("FAIL to_after got done=%b err=%b gnt=%b want 0000/0/0000", done, err, gnt);
        end
        tick;
    endtask

    task automatic test_fairness;
        logic [N-1:0] prev;
        logic [1:0]   w;
        int           last_rise;
        int           grants;
        do_reset;
        req = 4'b1111; mem_ready = 1'b1; mem_rdata = 32'h1;
        prev = '0; last_rise = -1; grants = 0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            tick;
            total++; if ($countones(gnt) > 1) begin
                bad++; $display("FAIL fair_onehot cyc=%0d got gnt=%b want at most one bit", cyc, gnt);
            end
            if (gnt !== 4'b0 && prev === 4'b0) begin
                w = model_pick(req);
                total++; if (gnt !== (4'b0001 << w)) begin
                    bad++; $display("FAIL fair_order grant#%0d got gnt=%b want %b", grants, gnt, 4'b0001 << w);
                end
                model_commit(w);
                if (last_rise >= 0) begin
                    total++; if (cyc - last_rise != 3) begin
                        bad++; $display("FAIL fair_gap grant#%0d got %0d cycles want 3", grants, cyc - last_rise);
                    end
                end
                last_rise = cyc;
                grants++;
            end
            prev = gnt;
        end
        total++; if (grants != 12) begin
            bad++; $display("FAIL fair_count got %0d grants want 12", grants);
        end
        req = '0; mem_ready = 1'b0;
        tick; tick;
    endtask

    task automatic test_random;
        logic [N-1:0]  m, eg;
        logic [1:0]    w;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, e_rdata, d;
        logic          e_we;
        int            lat;
        do_reset;
        e_rdata = '0;
        for (int it = 0; it < 40; it++) begin
            m = 4'($urandom);
            if (m == 4'b0) begin
                req = '0; mem_ready = 1'($urandom);
                tick;
                total++; if (gnt !== 4'b0 || mem_valid !== 1'b0) begin
                    bad++; $display("FAIL rnd_idle it=%0d got gnt=%b valid=%b want 0000/0", it, gnt, mem_valid);
                end
                m = 4'($urandom_range(1, 15));
            end
            req = m;
            req_we = 4'($urandom);
            for (int i = 0; i < N; i++) begin c_addr[i] = $urandom; c_wdata[i] = $urandom; end
            mem_ready = 1'($urandom);
            w = model_pick(m);
            eg = 4'b0001 << w;
            e_addr = c_addr[w]; e_wdata = c_wdata[w]; e_we = req_we[w];
            tick;
            total++; if (gnt !== eg || mem_valid !== 1'b1 || mem_addr !== e_addr || mem_wdata !== e_wdata || mem_we !== e_we) begin
                bad++; $display("FAIL rnd_grant it=%0d got gnt=%b v=%b a=%h wd=%h we=%b want %b/1/%h/%h/%b",
                                it, gnt, mem_valid, mem_addr, mem_wdata, mem_we, eg, e_addr, e_wdata, e_we);
            end
            lat = ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(1, 6);
            for (int c = 1; c <= TO; c++) begin
                d = $urandom;
                mem_ready = (c == lat); mem_rdata = d;
                req = 4'($urandom); req_we = 4'($urandom);
                for (int i = 0; i < N; i++) c_addr[i] = $urandom;
                tick;
                if (c == lat || c == TO) begin
                    e_rdata = (c == lat && !e_we) ? d : '0;
                    total++; if (done !== eg || err !== (c != lat) || rdata !== e_rdata || mem_valid !== 1'b0 || gnt !== eg) begin
                        bad++; $display("FAIL rnd_done it=%0d got done=%b err=%b rd=%h v=%b gnt=%b want %b/%b/%h/0/%b",
                                        it, done, err, rdata, mem_valid, gnt, eg, c != lat, e_rdata, eg);
                    end
                    break;
                end else begin
                    total++; if (mem_valid !== 1'b1 || done !== 4'b0 || mem_addr !== e_addr || gnt !== eg) begin
                        bad++; $display("FAIL rnd_busy it=%0d c=%0d got v=%b done=%b a=%h gnt=%b want 1/0000/%h/%b",
                                        it, c, mem_valid, done, mem_addr, gnt, e_addr, eg);
                    end
                end
            end
            model_commit(w);
            mem_ready = 1'($urandom);
            tick;
            total++; if (done !== 4'b0 || gnt !== 4'b0 || err !== 1'b0 || rdata !== e_rdata) begin
                bad++; $display("FAIL rnd_resp it=%0d got done=%b gnt=%b err=%b rd=%h want 0000/0000/0/%h",
                                it, done, gnt, err, rdata, e_rdata);
            end
        end
        req = '0; mem_ready = 1'b0;
        tick;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        test_reset;
        test_single_read;
        test_write;
        test_reset_mid_busy;
        test_withdrawal;
        test_timeout;
        test_fairness;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Round-robin arbiter that shares the single shared-memory/L2 port among the per-core L1 caches of the multicore cache simulator. Each L1 raises a miss/writeback request. The arbiter grants one core at a time, forwards that core's address, data and write flag to the memory port, and waits for the memory handshake. It then returns read data and a one-cycle `done` pulse to the winning core. A watchdog aborts transactions that the memory never acknowledges.

## Interface
- `NUM_CORES`, 4: number of L1 requesters (2–8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 64: maximum number of BUSY cycles allowed before abort (≥2).

- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input NUM_CORES: per-core request; the core holds it high until its `done` is seen.
- `req_we` input NUM_CORES: per-core write flag (1 = write, 0 = read).
- `req_addr` input NUM_CORES*ADDR_W: per-core address; core i uses slice [i*ADDR_W +: ADDR_W].
- `req_wdata` input NUM_CORES*DATA_W: per-core write data, sliced the same way.
- `gnt` output NUM_CORES: one-hot grant, or all zeros.
- `done` output NUM_CORES: one-cycle completion pulse, asserted only for the granted core.
- `err` output 1: qualifies `done`; 1 means the transaction timed out.
- `rdata` output DATA_W: read data, valid while `done` is high.
- `mem_valid` output 1: memory request valid.
- `mem_we` output 1: memory write flag.
- `mem_addr` output ADDR_W: memory address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_ready` input 1: memory accepts the request and completes it this cycle.
- `mem_rdata` input DATA_W: memory read data, valid when `mem_ready` is high.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- IDLE:
  - If any `req` bit is high, the arbiter picks a winner by round-robin and moves to BUSY.
  - The search starts at `last+1` mod NUM_CORES and takes the first set bit.
  - In the same edge it registers the winner's address, write data and write flag into `mem_*`, sets `gnt` to the winner's one-hot code, sets `mem_valid`=1 and clears the watchdog counter.
  - If no `req` bit is high, it stays in IDLE.
- BUSY:
  - `mem_valid` and the `mem_*` outputs are held stable.
  - `req`, `req_addr`, `req_wdata` and `req_we` changes are ignored, including withdrawal of `req`.
  - On `mem_ready`=1: capture `rdata` = `mem_rdata` (0 for writes), clear `mem_valid`, set `done[winner]`=1 and `err`=0, update `last` = winner, go to RESP.
  - If the counter reaches TIMEOUT-1 with `mem_ready`=0: same actions with `rdata`=0 and `err`=1.
  - Otherwise the counter increments.
- RESP: lasts exactly one cycle. At its closing edge the arbiter clears `done`, `err` and `gnt` and returns to IDLE. `rdata` holds its value until the next capture.
- Requester rule: a core drops `req` at the edge that ends its `done` cycle. IDLE samples `req` at its own closing edge, so a core that has just completed is never re-granted by stale `req`.
- `mem_ready` is ignored outside BUSY.
- Reset values:
  - State = IDLE and `last` = NUM_CORES-1, so core 0 has first priority.
  - `gnt`, `done`, `err` and `mem_valid` are 0.
  - `mem_we`, `mem_addr`, `mem_wdata` and `rdata` are 0.
- Reset asserted mid-transaction aborts it immediately: `mem_valid` drops asynchronously and no `done` is issued. The memory side treats this as a cancel.

## Timing
- Each transaction occupies at least 3 cycles: IDLE (1), BUSY (≥1), RESP (1).
- With `req` seen at edge k, `gnt` and `mem_valid` are high from k to k+1. If `mem_ready` is high at edge k+n, `done` is high from k+n to k+n+1.
- Back-to-back transactions from different cores are separated by one IDLE cycle.
- A timeout fires at the TIMEOUT-th BUSY edge, so BUSY lasts exactly TIMEOUT cycles.
- `gnt` is high throughout BUSY and RESP and is never multi-hot.
- With all `NUM_CORES` requesting continuously, each core is served once per NUM_CORES transactions.

## Test plan
- Single read: core 2 sets `req_addr`=0x100 and `req_we`=0; `mem_ready` goes high on the 3rd BUSY cycle with `mem_rdata`=0xDEADBEEF. Expect `gnt`=0100, `mem_addr`=0x100 for 3 cycles, then `done`=0100, `rdata`=0xDEADBEEF, `err`=0.
- Write: core 1 sets `req_we`=1 and `req_wdata`=0x55AA; `mem_ready` is immediate. Expect `mem_we`=1 and `mem_wdata`=0x55AA for 1 BUSY cycle, `done`=0010, `rdata`=0.
- Fairness after reset: all 4 cores request continuously with `mem_ready` tied high. Expect grant order 0,1,2,3,0,…, a new `gnt` every 3 cycles, and never two bits set.
- Timeout: core 3 requests and `mem_ready` stays 0. Expect `mem_valid` high for exactly 64 cycles, then `done`=1000, `err`=1, `rdata`=0, then IDLE.
- Reset mid-BUSY: assert `rst` in the 2nd BUSY cycle of a core 0 read. Expect `mem_valid`, `gnt` and `done` to be 0 immediately with no `done` pulse; after release, core 0 is served first again.
- Withdrawal: core 1 drops `req` during BUSY. Expect the transaction to still complete with `done`=0010, and no re-grant while `req` is low.
